// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and the load/store path,
// sequencing one req/gnt/rvalid transaction at a time with lane steering and load extension.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_valid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic              data_zero_extnd_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_done_o,
    output logic              data_err_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t            state, state_next;
    grant_t            last_grant, owner;
    logic              err_q, zext_q;
    logic [1:0]        size_q, lo_q;
    logic [XLEN-1:0]   rdata_q;

    logic              instr_elig, data_elig, grant_any, grant_data;
    logic              data_bad;
    logic [3:0]        data_be;
    logic [XLEN-1:0]   data_wrep, lane, load_ext;
    logic [1:0]        unused_instr_addr_bits;

    assign unused_instr_addr_bits = instr_addr_i[1:0];

    // A requester's level is still high during its own completion pulse; masking it there keeps
    // that stale level from being taken as a fresh access.
    assign instr_elig = instr_req_i && !instr_valid_o;
    assign data_elig  = data_req_i && !data_done_o;
    assign grant_any  = instr_elig || data_elig;
    assign grant_data = data_elig && (!instr_elig || last_grant == GRANT_INSTR);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_bad  = 1'b0;
        data_be   = 4'b1111;
        data_wrep = data_wdata_i;
        case (data_byte_i)
            SIZE_BYTE: begin
                data_be   = 4'b0001 << data_addr_i[1:0];
                data_wrep = {4{data_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                data_bad  = data_addr_i[0];
                data_be   = 4'b0011 << data_addr_i[1:0];
                data_wrep = {2{data_wdata_i[15:0]}};
            end
            SIZE_WORD: data_bad = |data_addr_i[1:0];
            default:   data_bad = 1'b1;
        endcase
    end

    // Halves are aligned, so shifting by the full byte offset also selects the half lane.
    assign lane = mem_rdata_i >> {lo_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (size_q)
            SIZE_BYTE: load_ext = {{24{~zext_q & lane[7]}}, lane[7:0]};
            SIZE_HALF: load_ext = {{16{~zext_q & lane[15]}}, lane[15:0]};
            default:   load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_any) state_next = (grant_data && data_bad) ? S_RESP : S_REQ;
            end
            S_REQ: begin
                if (mem_gnt_i) state_next = mem_we_o ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= GRANT_INSTR;
            owner         <= GRANT_INSTR;
            err_q         <= 1'b0;
            zext_q        <= 1'b0;
            size_q        <= '0;
            lo_q          <= '0;
            rdata_q       <= '0;
            instr_valid_o <= 1'b0;
            instr_rdata_o <= '0;
            data_done_o   <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
        end else begin
            instr_valid_o <= 1'b0;
            data_done_o   <= 1'b0;
            data_err_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any && grant_data) begin
                        last_grant <= GRANT_DATA;
                        owner      <= GRANT_DATA;
                        size_q     <= data_byte_i;
                        zext_q     <= data_zero_extnd_i;
                        lo_q       <= data_addr_i[1:0];
                        err_q      <= data_bad;
                        if (!data_bad) begin
                            mem_req_o   <= 1'b1;
                            mem_addr_o  <= {data_addr_i[ADDR_W-1:2], 2'b00};
                            mem_we_o    <= data_wr_i;
                            mem_be_o    <= data_be;
                            mem_wdata_o <= data_wrep;
                        end
                    end else if (grant_any) begin
                        last_grant  <= GRANT_INSTR;
                        owner       <= GRANT_INSTR;
                        err_q       <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= {instr_addr_i[ADDR_W-1:2], 2'b00};
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'b1111;
                        mem_wdata_o <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) mem_req_o <= 1'b0;
                end
                S_WAIT: begin
                    if (mem_rvalid_i) rdata_q <= (owner == GRANT_INSTR) ? mem_rdata_i : load_ext;
                end
                S_RESP: begin
                    if (owner == GRANT_INSTR) begin
                        instr_valid_o <= 1'b1;
                        instr_rdata_o <= rdata_q;
                    end else begin
                        data_done_o  <= 1'b1;
                        data_err_o   <= err_q;
                        data_rdata_o <= (err_q || mem_we_o) ? '0 : rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: fetch, loads, stores, errors, arbitration order,
// handshake hygiene and reset while a read is outstanding.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_wr_i, data_zero_extnd_i;
    logic [1:0]  data_byte_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_done_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int          checks = 0;
    int          errors = 0;
    bit          auto_mem = 1'b0;
    bit          pend_read = 1'b0;
    logic [31:0] mem_word = '0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] exp;
        logic [3:0]  be;
    } ld_vec_t;

    ld_vec_t ld_vecs[5] = '{
        '{32'h0000_0203, 2'b00, 1'b0, 32'hFFFF_FF80, 4'b1000},
        '{32'h0000_0203, 2'b00, 1'b1, 32'h0000_0080, 4'b1000},
        '{32'h0000_0402, 2'b01, 1'b0, 32'hFFFF_8011, 4'b1100},
        '{32'h0000_0400, 2'b01, 1'b1, 32'h0000_2233, 4'b0011},
        '{32'h0000_0404, 2'b10, 1'b0, 32'h8011_2233, 4'b1111}
    };

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_byte_i(data_byte_i),
        .data_zero_extnd_i(data_zero_extnd_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_done_o(data_done_o), .data_err_o(data_err_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: grant on the first request cycle, read data the following cycle.
    initial begin : responder
        forever begin
            @(posedge clk);
            #2;
            if (auto_mem) begin
                mem_rvalid_i = pend_read;
                pend_read    = mem_req_o && !mem_we_o;
                mem_gnt_i    = mem_req_o;
                mem_rdata_i  = mem_word;
            end else begin
                pend_read = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic run_instr(input logic [31:0] addr, output bit got, output int lat,
                             output logic [31:0] rdata, output logic [31:0] m_addr,
                             output logic [3:0] m_be, output logic m_we);
        bit saw;
        got = 1'b0; lat = 0; saw = 1'b0; rdata = 'x; m_addr = 'x; m_be = 'x; m_we = 1'bx;
        instr_addr_i = addr;
        instr_req_i  = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            if (mem_req_o && !saw) begin
                saw = 1'b1; m_addr = mem_addr_o; m_be = mem_be_o; m_we = mem_we_o;
            end
            if (instr_valid_o) begin
                got = 1'b1; lat = c; rdata = instr_rdata_o;
            end
        end
        instr_req_i = 1'b0;
    endtask

    task automatic run_data(input logic wr, input logic [1:0] size, input logic zext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output bit got, output int lat, output logic err,
                            output logic [31:0] rdata, output bit saw,
                            output logic [31:0] m_addr, output logic [3:0] m_be,
                            output logic m_we, output logic [31:0] m_wdata);
        got = 1'b0; lat = 0; saw = 1'b0; err = 1'bx; rdata = 'x;
        m_addr = 'x; m_be = 'x; m_we = 1'bx; m_wdata = 'x;
        data_wr_i = wr; data_byte_i = size; data_zero_extnd_i = zext;
        data_addr_i = addr; data_wdata_i = wdata;
        data_req_i = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            if (mem_req_o && !saw) begin
                saw = 1'b1; m_addr = mem_addr_o; m_be = mem_be_o; m_we = mem_we_o;
                m_wdata = mem_wdata_o;
            end
            if (data_done_o) begin
                got = 1'b1; lat = c; err = data_err_o; rdata = data_rdata_o;
            end
        end
        data_req_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({instr_valid_o, data_done_o, data_err_o, mem_req_o, mem_we_o, mem_be_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0",
                     {instr_valid_o, data_done_o, data_err_o, mem_req_o, mem_we_o, mem_be_o});
        end
        checks++;
        if ({instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o} !== 128'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0",
                     {instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bit got; int lat; logic [31:0] rd, ma; logic [3:0] be; logic we;
        auto_mem = 1'b1;
        mem_word = 32'hDEAD_BEEF;
        run_instr(32'h0000_0100, got, lat, rd, ma, be, we);
        checks++;
        if (!got || lat !== 4) begin
            errors++; $display("FAIL fetch_latency: got=%0b lat=%0d expected lat=4", got, lat);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", rd);
        end
        checks++;
        if ({ma, be, we} !== {32'h0000_0100, 4'b1111, 1'b0}) begin
            errors++; $display("FAIL fetch_cmd: addr=%h be=%b we=%b expected 100/1111/0", ma, be, we);
        end
        step();
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL fetch_single_pulse: valid=%b expected 0", instr_valid_o);
        end
    endtask

    task automatic test_load();
        bit got, saw; int lat; logic err, we; logic [31:0] rd, ma, wd; logic [3:0] be;
        auto_mem = 1'b1;
        mem_word = 32'h8011_2233;
        for (int i = 0; i < 5; i++) begin
            run_data(1'b0, ld_vecs[i].size, ld_vecs[i].zext, ld_vecs[i].addr, 32'h0,
                     got, lat, err, rd, saw, ma, be, we, wd);
            checks++;
            if (!got || lat !== 4 || err !== 1'b0) begin
                errors++; $display("FAIL load%0d_done: got=%0b lat=%0d err=%b expected lat=4 err=0",
                                   i, got, lat, err);
            end
            checks++;
            if (rd !== ld_vecs[i].exp) begin
                errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, rd, ld_vecs[i].exp);
            end
            checks++;
            if ({ma, be, we} !== {ld_vecs[i].addr & 32'hFFFF_FFFC, ld_vecs[i].be, 1'b0}) begin
                errors++; $display("FAIL load%0d_cmd: addr=%h be=%b we=%b expected %h/%b/0",
                                   i, ma, be, we, ld_vecs[i].addr & 32'hFFFF_FFFC, ld_vecs[i].be);
            end
            step();
        end
    endtask

    task automatic test_store();
        bit got, saw; int lat; logic err, we; logic [31:0] rd, ma, wd; logic [3:0] be;
        logic [31:0] s_addr[3]  = '{32'h0000_0402, 32'h0000_0001, 32'h0000_0008};
        logic [1:0]  s_size[3]  = '{2'b01, 2'b00, 2'b10};
        logic [31:0] s_wdata[3] = '{32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_F00D};
        logic [31:0] e_wdata[3] = '{32'hABCD_ABCD, 32'h7878_7878, 32'hCAFE_F00D};
        logic [3:0]  e_be[3]    = '{4'b1100, 4'b0010, 4'b1111};
        auto_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_data(1'b1, s_size[i], 1'b0, s_addr[i], s_wdata[i], got, lat, err, rd, saw, ma, be, we, wd);
            checks++;
            if (!got || lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
                errors++; $display("FAIL store%0d_done: got=%0b lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=0",
                                   i, got, lat, err, rd);
            end
            checks++;
            if ({ma, be, we, wd} !== {s_addr[i] & 32'hFFFF_FFFC, e_be[i], 1'b1, e_wdata[i]}) begin
                errors++; $display("FAIL store%0d_cmd: addr=%h be=%b we=%b wdata=%h expected %h/%b/1/%h",
                                   i, ma, be, we, wd, s_addr[i] & 32'hFFFF_FFFC, e_be[i], e_wdata[i]);
            end
            step();
        end
    endtask

    task automatic test_misaligned();
        bit got, saw; int lat; logic err, we; logic [31:0] rd, ma, wd; logic [3:0] be;
        logic        e_wr[3]   = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  e_size[3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] e_addr[3] = '{32'h0000_0406, 32'h0000_0000, 32'h0000_0401};
        auto_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_data(e_wr[i], e_size[i], 1'b0, e_addr[i], 32'hFFFF_FFFF, got, lat, err, rd, saw, ma, be, we, wd);
            checks++;
            if (!got || lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL err%0d_done: got=%0b lat=%0d err=%b rdata=%h expected lat=2 err=1 rdata=0",
                                   i, got, lat, err, rd);
            end
            checks++;
            if (saw !== 1'b0) begin
                errors++; $display("FAIL err%0d_no_req: mem_req seen=%0b expected 0", i, saw);
            end
            step();
            checks++;
            if ({data_done_o, data_err_o} !== 2'b00) begin
                errors++; $display("FAIL err%0d_single_pulse: done/err=%b expected 00", i, {data_done_o, data_err_o});
            end
        end
    endtask

    task automatic test_arbitration();
        int n = 0; int na = 0; bit prev_req = 1'b0; bit both = 1'b0;
        bit order[4]; logic [31:0] addrs[4];
        reset = 1'b1;
        step();
        reset = 1'b0;
        auto_mem = 1'b1;
        mem_word = 32'h1111_2222;
        data_wr_i = 1'b0; data_byte_i = 2'b10; data_zero_extnd_i = 1'b0;
        data_addr_i = 32'h0000_0010; instr_addr_i = 32'h0000_0020;
        data_req_i = 1'b1; instr_req_i = 1'b1;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            if (mem_req_o && !prev_req && na < 4) begin
                addrs[na] = mem_addr_o; na++;
            end
            prev_req = mem_req_o;
            if (instr_valid_o && data_done_o) both = 1'b1;
            if (data_done_o) begin
                order[n] = 1'b1; n++;
            end else if (instr_valid_o) begin
                order[n] = 1'b0; n++;
            end
            if (n == 4) begin
                data_req_i = 1'b0; instr_req_i = 1'b0;
            end
        end
        data_req_i = 1'b0; instr_req_i = 1'b0;
        checks++;
        if (n !== 4 || both !== 1'b0) begin
            errors++; $display("FAIL arb_count: completions=%0d overlap=%0b expected 4/0", n, both);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (order[i] !== ((i % 2) == 0)) begin
                errors++; $display("FAIL arb_order%0d: got %s expected %s", i,
                                   order[i] ? "DATA" : "INSTR", ((i % 2) == 0) ? "DATA" : "INSTR");
            end
            checks++;
            if (addrs[i] !== (((i % 2) == 0) ? 32'h0000_0010 : 32'h0000_0020)) begin
                errors++; $display("FAIL arb_addr%0d: got %h expected %h", i, addrs[i],
                                   ((i % 2) == 0) ? 32'h0000_0010 : 32'h0000_0020);
            end
        end
        step();
        step();
    endtask

    task automatic test_gnt_stall();
        auto_mem = 1'b0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        step();
        step();
        checks++;
        if ({mem_req_o, instr_valid_o, data_done_o} !== 3'b000) begin
            errors++; $display("FAIL idle_stray_handshake: req/valid/done=%b expected 000",
                               {mem_req_o, instr_valid_o, data_done_o});
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        data_wr_i = 1'b1; data_byte_i = 2'b00; data_zero_extnd_i = 1'b0;
        data_addr_i = 32'h0000_0101; data_wdata_i = 32'h0000_005A;
        data_req_i = 1'b1;
        step();
        data_addr_i = 32'h0000_03FF; data_wdata_i = 32'h0000_FFFF; data_byte_i = 2'b10; data_wr_i = 1'b0;
        mem_rvalid_i = 1'b1;
        step();
        checks++;
        if ({mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o} !==
            {1'b1, 32'h0000_0100, 4'b0010, 1'b1, 32'h5A5A_5A5A}) begin
            errors++; $display("FAIL stall_hold: req=%b addr=%h be=%b we=%b wdata=%h expected 1/100/0010/1/5a5a5a5a",
                               mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o);
        end
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        checks++;
        if ({mem_req_o, data_done_o} !== 2'b00) begin
            errors++; $display("FAIL stall_gnt_drop: req/done=%b expected 00", {mem_req_o, data_done_o});
        end
        step();
        data_req_i = 1'b0;
        checks++;
        if ({data_done_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL stall_done: done=%b err=%b rdata=%h expected 1/0/0",
                               data_done_o, data_err_o, data_rdata_o);
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        bit got; int lat; bit pulse = 1'b0; logic [31:0] rd, ma; logic [3:0] be; logic we;
        auto_mem = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        instr_addr_i = 32'h0000_0300;
        instr_req_i = 1'b1;
        step();
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_wait_req: req=%b expected 1", mem_req_o);
        end
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        reset = 1'b1;
        instr_req_i = 1'b0;
        step();
        reset = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        checks++;
        if ({mem_req_o, instr_valid_o, data_done_o, instr_rdata_o} !== 35'h0) begin
            errors++; $display("FAIL rst_wait_clear: req=%b valid=%b done=%b rdata=%h expected 0",
                               mem_req_o, instr_valid_o, data_done_o, instr_rdata_o);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            mem_rvalid_i = 1'b0;
            if (instr_valid_o || data_done_o || mem_req_o) pulse = 1'b1;
        end
        checks++;
        if (pulse !== 1'b0) begin
            errors++; $display("FAIL rst_wait_late_rvalid: activity=%0b expected 0", pulse);
        end
        auto_mem = 1'b1;
        mem_word = 32'h600D_F00D;
        run_instr(32'h0000_0304, got, lat, rd, ma, be, we);
        checks++;
        if (!got || lat !== 4 || rd !== 32'h600D_F00D || ma !== 32'h0000_0304) begin
            errors++; $display("FAIL rst_wait_refetch: got=%0b lat=%0d rdata=%h addr=%h expected lat=4 600df00d 304",
                               got, lat, rd, ma);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_byte_i = '0; data_zero_extnd_i = 1'b0;
        data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_misaligned();
        test_arbitration();
        test_gnt_stall();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
